mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_unit
// Purpose  : Iterative 32x32 multiply/multiply-accumulate unit with optional
//            restoring divider (enabled by macro MUL_UNIT_DIV_EN).
// Revision : 1.0
// ============================================================================
module mul_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic        wb_enable,
    output logic [1:0]  wb_mul,
    output logic [31:0] wb_data_1,
    output logic [31:0] wb_data_2
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_next_state;
    logic [4:0]  r_count;
    logic        r_legal, r_accum, r_neg_q;
    logic [31:0] r_m, r_hi, r_lo, r_wb_lo, r_wb_hi;
    logic        w_legal, w_signed, w_accum, w_accept;
    logic [31:0] w_mag_a, w_mag_b, w_step_hi, w_step_lo, w_res_lo, w_res_hi;
    logic [32:0] w_sum;
    logic [63:0] w_prod, w_signed_prod;
`ifdef MUL_UNIT_DIV_EN
    logic        r_div, r_div_zero, r_neg_r, w_div, w_ge;
    logic [32:0] w_rem_shift;
    logic [31:0] w_rem_diff;
`endif

    always_comb begin
        w_legal  = 1'b0;
        w_signed = 1'b0;
        w_accum  = 1'b0;
`ifdef MUL_UNIT_DIV_EN
        w_div    = 1'b0;
`endif
        case (op)
            3'd0: begin w_legal = 1'b1; w_signed = 1'b1; end
            3'd1: w_legal = 1'b1;
            3'd2: begin w_legal = 1'b1; w_signed = 1'b1; w_accum = 1'b1; end
            3'd3: begin w_legal = 1'b1; w_accum = 1'b1; end
`ifdef MUL_UNIT_DIV_EN
            3'd4: begin w_legal = 1'b1; w_signed = 1'b1; w_div = 1'b1; end
            3'd5: begin w_legal = 1'b1; w_div = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_mag_a  = (w_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_mag_b  = (w_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Shift-add step: {hi,lo} holds partial product above the unconsumed multiplier bits.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : 33'd0);

`ifdef MUL_UNIT_DIV_EN
    assign w_rem_shift = {r_hi, r_lo[31]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_m});
    assign w_rem_diff  = w_rem_shift[31:0] - r_m;

    always_comb begin
        w_step_hi = w_sum[32:1];
        w_step_lo = {w_sum[0], r_lo[31:1]};
        if (r_div) begin
            w_step_hi = w_ge ? w_rem_diff : w_rem_shift[31:0];
            w_step_lo = {r_lo[30:0], w_ge};
        end
    end
`else
    assign w_step_hi = w_sum[32:1];
    assign w_step_lo = {w_sum[0], r_lo[31:1]};
`endif

    assign w_prod = {w_step_hi, w_step_lo};

    always_comb begin
        w_signed_prod = r_neg_q ? (64'd0 - w_prod) : w_prod;
        w_res_hi      = w_signed_prod[63:32];
        w_res_lo      = w_signed_prod[31:0];
`ifdef MUL_UNIT_DIV_EN
        // Divide by zero leaves |a| in the remainder, so only the quotient is forced.
        if (r_div) begin
            w_res_lo = r_div_zero ? 32'hFFFF_FFFF
                                  : (r_neg_q ? (32'd0 - w_step_lo) : w_step_lo);
            w_res_hi = r_neg_r ? (32'd0 - w_step_hi) : w_step_hi;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = w_legal ? S_RUN : S_DONE;
            S_RUN:   if (r_count == 5'd31) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 5'd0;
            r_legal    <= 1'b0;
            r_accum    <= 1'b0;
            r_neg_q    <= 1'b0;
            r_m        <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_wb_lo    <= 32'd0;
            r_wb_hi    <= 32'd0;
`ifdef MUL_UNIT_DIV_EN
            r_div      <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_r    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_count <= 5'd0;
            r_legal <= w_legal;
            r_accum <= w_accum;
            r_neg_q <= w_signed & (src_a[31] ^ src_b[31]);
            r_hi    <= 32'd0;
`ifdef MUL_UNIT_DIV_EN
            r_div      <= w_div;
            r_div_zero <= (src_b == 32'd0);
            r_neg_r    <= w_signed & src_a[31];
            if (w_div) begin
                r_m  <= w_mag_b;
                r_lo <= w_mag_a;
            end else
`endif
            begin
                r_m  <= w_mag_a;
                r_lo <= w_mag_b;
            end
        end else if (r_state == S_RUN) begin
            r_count <= r_count + 5'd1;
            r_hi    <= w_step_hi;
            r_lo    <= w_step_lo;
            if (r_count == 5'd31) begin
                r_wb_lo <= w_res_lo;
                r_wb_hi <= w_res_hi;
            end
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        wb_enable = done && r_legal;
        wb_mul    = (done && r_legal) ? (r_accum ? 2'd2 : 2'd1) : 2'd0;
        wb_data_1 = r_wb_lo;
        wb_data_2 = r_wb_hi;
    end
endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_unit
// Purpose  : Self-checking bench for mul_unit against an arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_mul_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy, done, wb_enable;
    logic [1:0]  wb_mul;
    logic [31:0] wb_data_1, wb_data_2;

    int n_checks = 0;
    int n_errors = 0;

    mul_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .done      (done),
        .wb_enable (wb_enable),
        .wb_mul    (wb_mul),
        .wb_data_1 (wb_data_1),
        .wb_data_2 (wb_data_2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output bit legal, output logic [1:0] mode,
                                  output logic [31:0] lo, output logic [31:0] hi);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = int'(a);
        sb = int'(b);
        legal = 1'b1;
        lo = 32'd0;
        hi = 32'd0;
        case (o)
            3'd0, 3'd2: begin sp = longint'(sa) * longint'(sb); {hi, lo} = 64'(sp); end
            3'd1, 3'd3: begin up = 64'(a) * 64'(b); {hi, lo} = up; end
`ifdef MUL_UNIT_DIV_EN
            3'd4: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 32'd0; end
                else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            end
            3'd5: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
`endif
            default: legal = 1'b0;
        endcase
        mode = !legal ? 2'd0 : ((o == 3'd2 || o == 3'd3) ? 2'd2 : 2'd1);
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
        bit          lg, early;
        logic [1:0]  md;
        logic [31:0] lo, hi;
        int          cyc, seen;
        model(o, a, b, lg, md, lo, hi);
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 3'($urandom);
        cyc = 1; seen = 0; early = 1'b0;
        while (cyc <= 40 && seen == 0) begin
            if (done) seen = cyc;
            else begin
                if (wb_enable || wb_mul != 2'd0) early = 1'b1;
                start = poke && (cyc == 10);
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        check($sformatf("done_cycle op%0d", o), 64'(seen), lg ? 64'd33 : 64'd1);
        check($sformatf("early_wb op%0d", o), 64'(early), 64'd0);
        if (seen != 0) begin
            check($sformatf("wb_enable op%0d", o), 64'(wb_enable), 64'(lg));
            check($sformatf("wb_mul op%0d", o), 64'(wb_mul), 64'(md));
            check($sformatf("busy_in_done op%0d", o), 64'(busy), 64'd1);
            if (lg) begin
                check($sformatf("lo op%0d a=%h b=%h", o, a, b), 64'(wb_data_1), 64'(lo));
                check($sformatf("hi op%0d a=%h b=%h", o, a, b), 64'(wb_data_2), 64'(hi));
            end
            start = poke;
            tick();
            start = 1'b0;
            check($sformatf("done_drop op%0d", o), 64'(done), 64'd0);
            check($sformatf("idle_after op%0d", o), 64'(busy), 64'd0);
            tick();
            tick();
            check($sformatf("single_done op%0d", o), 64'({done, busy, wb_enable}), 64'd0);
            if (lg) begin
                check($sformatf("lo_hold op%0d", o), 64'(wb_data_1), 64'(lo));
                check($sformatf("hi_hold op%0d", o), 64'(wb_data_2), 64'(hi));
            end
        end else begin
            apply_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit flag;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1;
        repeat (3) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_wb", 64'({wb_enable, wb_mul}), 64'd0);
        check("reset_data", {wb_data_2, wb_data_1}, 64'd0);
        rst = 1'b0;
        tick();

        run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd2, 32'd7, 32'd6, 1'b0);
        run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'd6, 32'd1, 32'd2, 1'b0);
        run_op(3'd7, 32'd3, 32'd4, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd5, 32'd5, 32'd0, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_F000, 32'd0, 1'b0);
        run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 1'b0);

        // Extra start pulses mid-run and in the DONE cycle must be ignored.
        run_op(3'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b1);

        // Reset in the middle of a multiply aborts it silently.
        op = 3'd0; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_data", {wb_data_2, wb_data_1}, 64'd0);
        flag = 1'b0;
        repeat (40) begin
            if (done || wb_enable) flag = 1'b1;
            tick();
        end
        check("abort_no_done", 64'(flag), 64'd0);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; op = 3'd1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_priority", 64'(busy), 64'd0);
        tick();
        check("rst_priority_idle", 64'({busy, done}), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op(ro, ra, rb, (i % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
